// File: rtl/divisibility_by_n_if.sv
// Serial bit stream in, running remainder and frame verdicts out, for divisibility_by_n.
// Widths are derived here the same way as in the checker, so both ends agree.
interface divisibility_by_n_if #(
  parameter int DIVISOR   = 5,
  parameter int FRAME_LEN = 8
);
  localparam int SW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam int CW = $clog2(FRAME_LEN + 1);

  logic          clear;
  logic          in_valid;
  logic          in;
  logic [SW-1:0] present_state;
  logic [SW-1:0] next_state;
  logic          q;
  logic [CW-1:0] bit_count;
  logic          frame_done;
  logic          frame_q;

  modport master (
    output clear, in_valid, in,
    input  present_state, next_state, q, bit_count, frame_done, frame_q
  );

  modport slave (
    input  clear, in_valid, in,
    output present_state, next_state, q, bit_count, frame_done, frame_q
  );
endinterface

// File: rtl/divisibility_by_n.sv
// Serial remainder-mod-DIVISOR checker; per-word verdicts when DIVN_FRAME_EN is defined.
// present_state one edge after an accepted bit, q/next_state combinational; no backpressure, in_valid=0 holds.
module divisibility_by_n #(
  parameter int DIVISOR   = 5,
  parameter bit MSB_FIRST = 1'b1,
  parameter int FRAME_LEN = 8
) (
  input logic          clk,
  input logic          reset,
  divisibility_by_n_if.slave bus
);
  localparam int SW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [SW:0]   DIV_X = (SW+1)'(DIVISOR);
  localparam logic [SW-1:0] W_ONE = SW'(1);
  localparam logic [SW-1:0] W_TWO = (DIVISOR == 2) ? '0 : SW'(2);

  logic [SW-1:0] ps;
  logic [SW-1:0] w;
  logic [SW-1:0] ns;
  logic [SW-1:0] w_nxt;
  logic [SW-1:0] nxt;
  logic [CW-1:0] bc;
  logic [SW:0]   t;
  logic [SW:0]   t_red;
  logic [SW:0]   w_dbl;
  logic [SW:0]   w_red;

  // Both operands are below DIVISOR, so a single conditional subtract fully reduces.
  always_comb begin
    if (MSB_FIRST) t = {ps, bus.in};
    else           t = {1'b0, ps} + (bus.in ? {1'b0, w} : '0);
    t_red = (t >= DIV_X) ? t - DIV_X : t;
    ns    = t_red[SW-1:0];
    w_dbl = {w, 1'b0};
    w_red = (w_dbl >= DIV_X) ? w_dbl - DIV_X : w_dbl;
    w_nxt = w_red[SW-1:0];
  end

  // At a frame boundary this still shows the remainder of the completed word.
  always_comb begin
    nxt = ps;
    if (bus.clear)         nxt = bus.in_valid ? SW'(bus.in) : '0;
    else if (bus.in_valid) nxt = ns;
  end

`ifdef DIVN_FRAME_EN
  logic frame_done_r;
  logic frame_q_r;
  logic last_bit;

  assign last_bit = (bc == CW'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps           <= '0;
      w            <= W_ONE;
      bc           <= '0;
      frame_done_r <= 1'b0;
      frame_q_r    <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (bus.clear) begin
        ps <= bus.in_valid ? SW'(bus.in) : '0;
        w  <= bus.in_valid ? W_TWO : W_ONE;
        bc <= bus.in_valid ? CW'(1) : '0;
      end else if (bus.in_valid) begin
        if (last_bit) begin
          frame_done_r <= 1'b1;
          frame_q_r    <= (ns == '0);
          ps           <= '0;
          w            <= W_ONE;
          bc           <= '0;
        end else begin
          ps <= ns;
          w  <= w_nxt;
          bc <= bc + CW'(1);
        end
      end
    end
  end

  assign bus.frame_done = frame_done_r;
  assign bus.frame_q    = frame_q_r;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps <= '0;
      w  <= W_ONE;
      bc <= '0;
    end else if (bus.clear) begin
      ps <= bus.in_valid ? SW'(bus.in) : '0;
      w  <= bus.in_valid ? W_TWO : W_ONE;
      bc <= bus.in_valid ? CW'(1) : '0;
    end else if (bus.in_valid) begin
      ps <= ns;
      w  <= w_nxt;
      if (bc != '1) bc <= bc + CW'(1);
    end
  end

  assign bus.frame_done = 1'b0;
  assign bus.frame_q    = 1'b0;
`endif

  assign bus.present_state = ps;
  assign bus.next_state    = nxt;
  assign bus.q             = (ps == '0);
  assign bus.bit_count     = bc;
endmodule

// File: tb/tb_divisibility_by_n.sv
// Directed checks of divisibility_by_n: DIVISOR 5/7 MSB-first, DIVISOR 3 LSB-first.
module tb_divisibility_by_n;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  divisibility_by_n_if #(.DIVISOR(5), .FRAME_LEN(8)) b5 ();
  divisibility_by_n_if #(.DIVISOR(3), .FRAME_LEN(8)) b3 ();
  divisibility_by_n_if #(.DIVISOR(7), .FRAME_LEN(8)) b7 ();

  divisibility_by_n #(.DIVISOR(5), .MSB_FIRST(1'b1), .FRAME_LEN(8)) u5 (.clk(clk), .reset(rst_n), .bus(b5));
  divisibility_by_n #(.DIVISOR(3), .MSB_FIRST(1'b0), .FRAME_LEN(8)) u3 (.clk(clk), .reset(rst_n), .bus(b3));
  divisibility_by_n #(.DIVISOR(7), .MSB_FIRST(1'b1), .FRAME_LEN(8)) u7 (.clk(clk), .reset(rst_n), .bus(b7));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests++; if ({int'(b5.present_state), int'(b3.present_state), int'(b7.present_state)} !== {32'd0, 32'd0, 32'd0}) begin
      fails++; $display("FAIL reset_ps got %0d/%0d/%0d want 0/0/0", b5.present_state, b3.present_state, b7.present_state); end
    tests++; if ({b5.q, b3.q, b7.q} !== 3'b111) begin
      fails++; $display("FAIL reset_q got %b want 111", {b5.q, b3.q, b7.q}); end
    tests++; if ({int'(b5.bit_count), int'(b3.bit_count), int'(b7.bit_count)} !== {32'd0, 32'd0, 32'd0}) begin
      fails++; $display("FAIL reset_bit_count got %0d/%0d/%0d want 0", b5.bit_count, b3.bit_count, b7.bit_count); end
    tests++; if ({b5.frame_done, b5.frame_q, b7.frame_done, b7.frame_q} !== 4'b0000) begin
      fails++; $display("FAIL reset_frame got %b want 0000", {b5.frame_done, b5.frame_q, b7.frame_done, b7.frame_q}); end
    tests++; if (int'(u3.w) !== 1) begin
      fails++; $display("FAIL reset_w got %0d want 1", u3.w); end
  endtask

  task automatic test_msb_div5();
    logic [3:0] bits;
    int eps[4] = '{1, 2, 0, 0};
    logic eq[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bits = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      b5.in_valid = 1'b1; b5.in = bits[3-i];
      #1;
      tests++; if (int'(b5.next_state) !== eps[i]) begin
        fails++; $display("FAIL msb5_next[%0d] got %0d want %0d", i, b5.next_state, eps[i]); end
      tick();
      tests++; if (int'(b5.present_state) !== eps[i]) begin
        fails++; $display("FAIL msb5_ps[%0d] got %0d want %0d", i, b5.present_state, eps[i]); end
      tests++; if (b5.q !== eq[i]) begin
        fails++; $display("FAIL msb5_q[%0d] got %b want %b", i, b5.q, eq[i]); end
      tests++; if (int'(b5.bit_count) !== i + 1) begin
        fails++; $display("FAIL msb5_count[%0d] got %0d want %0d", i, b5.bit_count, i + 1); end
    end
    b5.in_valid = 1'b0;
  endtask

  task automatic test_lsb_div3();
    logic bits[3] = '{1'b0, 1'b1, 1'b1};
    int ew[3]  = '{1, 2, 1};
    int eps[3] = '{0, 2, 0};
    for (int i = 0; i < 3; i++) begin
      b3.in_valid = 1'b1; b3.in = bits[i];
      #1;
      tests++; if (int'(u3.w) !== ew[i]) begin
        fails++; $display("FAIL lsb3_w[%0d] got %0d want %0d", i, u3.w, ew[i]); end
      tick();
      tests++; if (int'(b3.present_state) !== eps[i]) begin
        fails++; $display("FAIL lsb3_ps[%0d] got %0d want %0d", i, b3.present_state, eps[i]); end
      if (i == 1) begin
        b3.in_valid = 1'b0; b3.in = 1'b1;
        for (int g = 0; g < 2; g++) begin
          #1;
          tests++; if (int'(b3.next_state) !== 2) begin
            fails++; $display("FAIL lsb3_gap_next[%0d] got %0d want 2", g, b3.next_state); end
          tick();
          tests++; if ({int'(b3.present_state), int'(u3.w), int'(b3.bit_count)} !== {32'd2, 32'd1, 32'd2}) begin
            fails++; $display("FAIL lsb3_gap_hold[%0d] got ps=%0d w=%0d cnt=%0d want 2/1/2", g, b3.present_state, u3.w, b3.bit_count); end
        end
      end
    end
    tests++; if (b3.q !== 1'b1 || int'(b3.bit_count) !== 3) begin
      fails++; $display("FAIL lsb3_final got q=%b cnt=%0d want 1/3", b3.q, b3.bit_count); end
    b3.in_valid = 1'b0;
  endtask

  task automatic test_hold_div7();
    b7.in_valid = 1'b1; b7.in = 1'b1; tick(); tick();
    tests++; if (int'(b7.present_state) !== 3) begin
      fails++; $display("FAIL hold7_pre got %0d want 3", b7.present_state); end
    b7.in_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      b7.in = g[0];
      #1;
      tests++; if (int'(b7.next_state) !== 3) begin
        fails++; $display("FAIL hold7_next[%0d] got %0d want 3", g, b7.next_state); end
      tick();
      tests++; if ({int'(b7.present_state), int'(b7.bit_count)} !== {32'd3, 32'd2}) begin
        fails++; $display("FAIL hold7_regs[%0d] got ps=%0d cnt=%0d want 3/2", g, b7.present_state, b7.bit_count); end
    end
    b7.in_valid = 1'b1; b7.in = 1'b0; tick();
    tests++; if ({int'(b7.present_state), int'(b7.bit_count)} !== {32'd6, 32'd3}) begin
      fails++; $display("FAIL hold7_resume got ps=%0d cnt=%0d want 6/3", b7.present_state, b7.bit_count); end
    b7.in_valid = 1'b0; b7.clear = 1'b1; tick(); b7.clear = 1'b0;
    tests++; if ({int'(b7.present_state), int'(b7.bit_count), b7.q} !== {32'd0, 32'd0, 1'b1}) begin
      fails++; $display("FAIL hold7_clear got ps=%0d cnt=%0d q=%b want 0/0/1", b7.present_state, b7.bit_count, b7.q); end
  endtask

  task automatic test_clear_div5();
    b5.in_valid = 1'b1; b5.in = 1'b1; tick(); tick();
    tests++; if (int'(b5.present_state) !== 3) begin
      fails++; $display("FAIL clear5_pre got %0d want 3", b5.present_state); end
    b5.clear = 1'b1; b5.in_valid = 1'b1; b5.in = 1'b1;
    #1;
    tests++; if (int'(b5.next_state) !== 1) begin
      fails++; $display("FAIL clear5_next got %0d want 1", b5.next_state); end
    tick();
    tests++; if ({int'(b5.present_state), int'(b5.bit_count), b5.q} !== {32'd1, 32'd1, 1'b0}) begin
      fails++; $display("FAIL clear5_bit got ps=%0d cnt=%0d q=%b want 1/1/0", b5.present_state, b5.bit_count, b5.q); end
    b5.in_valid = 1'b0; tick(); b5.clear = 1'b0;
    tests++; if ({int'(b5.present_state), int'(b5.bit_count), b5.q} !== {32'd0, 32'd0, 1'b1}) begin
      fails++; $display("FAIL clear5_idle got ps=%0d cnt=%0d q=%b want 0/0/1", b5.present_state, b5.bit_count, b5.q); end
  endtask

`ifdef DIVN_FRAME_EN
  task automatic test_frame();
    logic [15:0] stream;
    int eps[16] = '{0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0};
    int ens, ecnt;
    logic efd, efq;
    stream = 16'h1C1D;
    for (int i = 0; i < 16; i++) begin
      b7.in_valid = 1'b1; b7.in = stream[15-i];
      ens  = (i == 15) ? 1 : eps[i];
      efd  = (i == 7 || i == 15);
      efq  = (i >= 7 && i < 15);
      ecnt = ((i % 8) == 7) ? 0 : (i % 8) + 1;
      #1;
      tests++; if (int'(b7.next_state) !== ens) begin
        fails++; $display("FAIL frame_next[%0d] got %0d want %0d", i, b7.next_state, ens); end
      tick();
      tests++; if ({int'(b7.present_state), int'(b7.bit_count), b7.frame_done, b7.frame_q} !== {eps[i], ecnt, efd, efq}) begin
        fails++; $display("FAIL frame_regs[%0d] got ps=%0d cnt=%0d done=%b fq=%b want %0d/%0d/%b/%b",
                          i, b7.present_state, b7.bit_count, b7.frame_done, b7.frame_q, eps[i], ecnt, efd, efq); end
    end
    b7.in_valid = 1'b0; tick();
    tests++; if (b7.frame_done !== 1'b0) begin
      fails++; $display("FAIL frame_done_pulse got %b want 0", b7.frame_done); end
  endtask
`else
  task automatic test_no_frame();
    b7.in_valid = 1'b1; b7.in = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      tests++; if ({b7.frame_done, b7.frame_q} !== 2'b00) begin
        fails++; $display("FAIL noframe_flags[%0d] got %b want 00", i, {b7.frame_done, b7.frame_q}); end
    end
    b7.in_valid = 1'b0;
    tests++; if ({int'(b7.present_state), int'(b7.bit_count)} !== {32'd3, 32'd15}) begin
      fails++; $display("FAIL noframe_sat got ps=%0d cnt=%0d want 3/15", b7.present_state, b7.bit_count); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [2:0] bits;
    bits = 3'b100;
    b7.clear = 1'b1; b7.in_valid = 1'b1; b7.in = 1'b1; tick(); b7.clear = 1'b0;
    for (int i = 1; i < 3; i++) begin b7.in = bits[2-i]; tick(); end
    tests++; if ({int'(b7.present_state), int'(b7.bit_count)} !== {32'd4, 32'd3}) begin
      fails++; $display("FAIL rstmid_pre got ps=%0d cnt=%0d want 4/3", b7.present_state, b7.bit_count); end
    #3 rst_n = 1'b0;
    #1;
    tests++; if ({int'(b7.present_state), int'(b7.bit_count), b7.q, b7.frame_done, b7.frame_q} !== {32'd0, 32'd0, 3'b100}) begin
      fails++; $display("FAIL rstmid_async got ps=%0d cnt=%0d q=%b done=%b fq=%b want 0/0/1/0/0",
                        b7.present_state, b7.bit_count, b7.q, b7.frame_done, b7.frame_q); end
    tick(); tick();
    rst_n = 1'b1; b7.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++; if (b7.frame_done !== 1'b0) begin
        fails++; $display("FAIL rstmid_no_done[%0d] got %b want 0", i, b7.frame_done); end
    end
    b7.in_valid = 1'b1; b7.in = 1'b1; tick(); b7.in_valid = 1'b0;
    tests++; if ({int'(b7.present_state), int'(b7.bit_count)} !== {32'd1, 32'd1}) begin
      fails++; $display("FAIL rstmid_restart got ps=%0d cnt=%0d want 1/1", b7.present_state, b7.bit_count); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    b5.clear = 1'b0; b5.in_valid = 1'b0; b5.in = 1'b0;
    b3.clear = 1'b0; b3.in_valid = 1'b0; b3.in = 1'b0;
    b7.clear = 1'b0; b7.in_valid = 1'b0; b7.in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_msb_div5();
    test_lsb_div3();
    test_hold_div7();
    test_clear_div5();
`ifdef DIVN_FRAME_EN
    test_frame();
`else
    test_no_frame();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
